// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  localparam int REQ_COUNT = 2;

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Two-input multiplexer used to steer requester payload onto the memory port.
module Multiplexer2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in2 : in1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters.
// The grant is held from issue until the granted requester's response returns.
//
// state     | meaning
// ARB_IDLE  | no transaction outstanding; arbitrate among valid requesters
// ARB_ISSUE | request driven to memory, waiting for mem_ready
// ARB_WAIT  | request accepted, waiting for mem_rvalid
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req0_we,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic                  req1_we,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  grant_sel,
  output logic                  busy
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_grant_sel;
  logic       w_grant_nxt;
  logic       r_last_grant;

  logic [REQ_COUNT-1:0] w_req_valid;
  logic [REQ_COUNT-1:0] w_grant_onehot;
  logic [REQ_COUNT-1:0] w_ready;
  logic [REQ_COUNT-1:0] w_rvalid;

  assign w_req_valid    = {req1_valid, req0_valid};
  assign w_grant_onehot = r_grant_sel ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_grant_sel  <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_sel <= w_grant_nxt;
      if (r_state == ARB_WAIT && mem_rvalid) begin
        r_last_grant <= r_grant_sel;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_sel;
    case (r_state)
      ARB_IDLE: begin
        if (|w_req_valid) begin
          w_state_nxt = ARB_ISSUE;
          case (w_req_valid)
            2'b01:   w_grant_nxt = 1'b0;
            2'b10:   w_grant_nxt = 1'b1;
            default: w_grant_nxt = ~r_last_grant;
          endcase
        end
      end
      ARB_ISSUE: begin
        if (mem_ready) begin
          w_state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Handshakes are steered only to the granted port; rvalid outside WAIT is dropped.
  assign w_ready  = (r_state == ARB_ISSUE && mem_ready)  ? w_grant_onehot : '0;
  assign w_rvalid = (r_state == ARB_WAIT  && mem_rvalid) ? w_grant_onehot : '0;

  assign req0_ready  = w_ready[0];
  assign req1_ready  = w_ready[1];
  assign req0_rvalid = w_rvalid[0];
  assign req1_rvalid = w_rvalid[1];
  assign req0_rdata  = mem_rdata;
  assign req1_rdata  = mem_rdata;

  assign mem_valid = (r_state == ARB_ISSUE);
  assign busy      = (r_state == ARB_ISSUE) || (r_state == ARB_WAIT);
  assign grant_sel = r_grant_sel;

  Multiplexer2 #(.WIDTH(ADDR_WIDTH)) u_mux_addr (
    .in1 (req0_addr),
    .in2 (req1_addr),
    .sel (r_grant_sel),
    .out (mem_addr)
  );

  Multiplexer2 #(.WIDTH(DATA_WIDTH)) u_mux_wdata (
    .in1 (req0_wdata),
    .in2 (req1_wdata),
    .sel (r_grant_sel),
    .out (mem_wdata)
  );

  Multiplexer2 #(.WIDTH(1)) u_mux_we (
    .in1 (req0_we),
    .in2 (req1_we),
    .sel (r_grant_sel),
    .out (mem_we)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction table with scoreboard plus
// hand-written sequences for stray responses and reset during WAIT.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_we, req0_ready, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_we, req1_ready, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          mem_valid, mem_we, mem_ready, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          grant_sel, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_we     (req0_we),
    .req0_ready  (req0_ready),
    .req0_rvalid (req0_rvalid),
    .req0_rdata  (req0_rdata),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_we     (req1_we),
    .req1_ready  (req1_ready),
    .req1_rvalid (req1_rvalid),
    .req1_rdata  (req1_rdata),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .grant_sel   (grant_sel),
    .busy        (busy)
  );

  typedef struct {
    bit          v0;
    bit          v1;
    logic [31:0] a0;
    logic [31:0] a1;
    bit          we0;
    bit          we1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    int          stall;
    logic [31:0] rdata;
    bit          exp_port;
  } vec_t;

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          we;
    logic [31:0] rdata;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction: IDLE -> ISSUE (with stalls) -> WAIT -> response.
  task automatic run_txn(input vec_t v);
    sb_t e;
    sb_t got;
    @(negedge clk);
    req0_valid = v.v0; req0_addr = v.a0; req0_we = v.we0; req0_wdata = v.wd0;
    req1_valid = v.v1; req1_addr = v.a1; req1_we = v.we1; req1_wdata = v.wd1;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    e.port  = v.exp_port;
    e.addr  = v.exp_port ? v.a1  : v.a0;
    e.wdata = v.exp_port ? v.wd1 : v.wd0;
    e.we    = v.exp_port ? v.we1 : v.we0;
    e.rdata = v.rdata;
    sb_q.push_back(e);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_mem_valid", mem_valid, 0);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("stall_mem_valid", mem_valid, 1);
      chk("stall_addr", mem_addr, e.addr);
      chk("stall_we", mem_we, e.we);
      chk("stall_grant", grant_sel, e.port);
      chk("stall_ready", {req1_ready, req0_ready}, 0);
      chk("stall_busy", busy, 1);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    got = sb_q.pop_front();
    chk("issue_mem_valid", mem_valid, 1);
    chk("issue_addr", mem_addr, got.addr);
    chk("issue_wdata", mem_wdata, got.wdata);
    chk("issue_we", mem_we, got.we);
    chk("issue_grant", grant_sel, got.port);
    chk("issue_req0_ready", req0_ready, !got.port);
    chk("issue_req1_ready", req1_ready, got.port);
    @(negedge clk);
    mem_ready = 1'b0;
    if (got.port) req1_valid = 1'b0;
    else          req0_valid = 1'b0;
    #1;
    chk("wait_mem_valid", mem_valid, 0);
    chk("wait_busy", busy, 1);
    chk("wait_rvalid", {req1_rvalid, req0_rvalid}, 0);
    chk("wait_grant", grant_sel, got.port);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = got.rdata;
    #1;
    chk("resp_req0_rvalid", req0_rvalid, !got.port);
    chk("resp_req1_rvalid", req1_rvalid, got.port);
    chk("resp_req0_rdata", req0_rdata, got.rdata);
    chk("resp_req1_rdata", req1_rdata, got.rdata);
    chk("resp_ready", {req1_ready, req0_ready}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // v0 v1 a0 a1 we0 we1 wd0 wd1 stall rdata exp_port
    vecs[0] = '{1, 1, 32'h10,  32'h20, 0, 0, 32'h0,    32'h0,  0, 32'hA0A00001, 0};
    vecs[1] = '{1, 1, 32'h10,  32'h20, 0, 0, 32'h0,    32'h0,  1, 32'hA0A00002, 1};
    vecs[2] = '{1, 1, 32'h14,  32'h24, 0, 0, 32'h0,    32'h0,  0, 32'hA0A00003, 0};
    vecs[3] = '{1, 0, 32'h100, 32'h0,  0, 0, 32'h0,    32'h0,  0, 32'hDEADBEEF, 0};
    vecs[4] = '{0, 1, 32'h0,   32'h40, 0, 1, 32'h0,    32'h55, 3, 32'hA0A00004, 1};
    vecs[5] = '{1, 0, 32'h80,  32'h0,  1, 0, 32'h1234, 32'h0,  1, 32'hA0A00005, 0};
    vecs[6] = '{1, 1, 32'h88,  32'h48, 0, 1, 32'h0,    32'h66, 0, 32'hA0A00006, 1};
    vecs[7] = '{0, 1, 32'h0,   32'h4C, 0, 0, 32'h0,    32'h0,  2, 32'hA0A00007, 1};
    vecs[8] = '{1, 1, 32'h8C,  32'h50, 1, 0, 32'h77,   32'h0,  0, 32'hA0A00008, 0};

    reset = 1'b1;
    req0_valid = 0; req0_addr = 0; req0_wdata = 0; req0_we = 0;
    req1_valid = 0; req1_addr = 0; req1_wdata = 0; req1_we = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_sel, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_rvalid", {req1_rvalid, req0_rvalid}, 0);

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);
    chk("sb_empty", sb_q.size(), 0);

    // Stray responses in IDLE and ISSUE are dropped and do not move the FSM.
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    #1;
    chk("stray_idle_rvalid", {req1_rvalid, req0_rvalid}, 0);
    chk("stray_idle_busy", busy, 0);
    @(negedge clk);
    mem_rvalid = 0; req0_valid = 1; req0_addr = 32'h300; req0_we = 0;
    #1;
    chk("stray_idle_hold", busy, 0);
    @(negedge clk);
    mem_rvalid = 1;
    #1;
    chk("stray_issue_rvalid", {req1_rvalid, req0_rvalid}, 0);
    chk("stray_issue_mem_valid", mem_valid, 1);
    chk("stray_issue_grant", grant_sel, 0);
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    chk("stray_still_issue", mem_valid, 1);
    chk("stray_addr", mem_addr, 32'h300);
    @(negedge clk);
    mem_ready = 1;
    #1;
    chk("stray_req0_ready", req0_ready, 1);
    @(negedge clk);
    mem_ready = 0; req0_valid = 0;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h0000_1111;
    #1;
    chk("stray_final_rvalid", {req1_rvalid, req0_rvalid}, 2'b01);

    // Reset during WAIT with grant on port 1, then a late response.
    @(negedge clk);
    mem_rvalid = 0;
    req0_valid = 1; req0_addr = 32'h500; req1_valid = 1; req1_addr = 32'h600;
    #1;
    chk("rw_idle_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("rw_grant1", grant_sel, 1);
    chk("rw_addr1", mem_addr, 32'h600);
    @(negedge clk);
    mem_ready = 1;
    #1;
    chk("rw_req1_ready", req1_ready, 1);
    @(negedge clk);
    mem_ready = 0; reset = 1; req0_valid = 0; req1_valid = 0;
    #1;
    chk("rw_in_wait", busy, 1);
    @(negedge clk);
    reset = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0000;
    #1;
    chk("rw_late_rvalid", {req1_rvalid, req0_rvalid}, 0);
    chk("rw_busy", busy, 0);
    chk("rw_grant", grant_sel, 0);
    chk("rw_mem_valid", mem_valid, 0);
    @(negedge clk);
    mem_rvalid = 0; req0_valid = 1; req1_valid = 1;
    #1;
    chk("rw_idle2", busy, 0);
    @(negedge clk);
    #1;
    chk("rw_tie_grant0", grant_sel, 0);
    chk("rw_tie_addr", mem_addr, 32'h500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter sharing one memory port, e.g. instruction fetch (port 0) and load/store unit (port 1).
- Selects one requester using round-robin.
- Holds the grant until that requester's response returns.
- Steers request payload onto the shared port through Multiplexer2 instances driven by a registered select.
- Sits between the core's fetch/LSU stages and the memory interface.

Parameters:
ADDR_WIDTH, 32, address width of requesters and memory port
DATA_WIDTH, 32, write/read data width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a transaction pending
req0_addr  input  ADDR_WIDTH  requester 0 address
req0_wdata  input  DATA_WIDTH  requester 0 write data
req0_we  input  1  requester 0 write enable
req0_ready  output  1  requester 0 request accepted this cycle
req0_rvalid  output  1  response for requester 0
req0_rdata  output  DATA_WIDTH  response data for requester 0
req1_valid, req1_addr, req1_wdata, req1_we, req1_ready, req1_rvalid, req1_rdata  same as port 0, for requester 1
mem_valid  output  1  request valid to memory
mem_addr  output  ADDR_WIDTH  muxed address
mem_wdata  output  DATA_WIDTH  muxed write data
mem_we  output  1  muxed write enable
mem_ready  input  1  memory accepts request
mem_rvalid  input  1  memory response valid; one per accepted request, writes included
mem_rdata  input  DATA_WIDTH  memory response data
grant_sel  output  1  registered current/last grant index
busy  output  1  high in ISSUE or WAIT

Behaviour:
Clock and reset: single clock clk; reset is synchronous and active-high.

Reset values:
- state=IDLE, grant_sel=0, last_grant=1 (so requester 0 wins the first tie).
- mem_valid, req*_ready, req*_rvalid and busy all 0.

FSM:
- IDLE:
  - If neither valid, stay.
  - If exactly one valid, grant_sel<=that index.
  - If both valid, grant_sel<=~last_grant.
  - On any valid, next state is ISSUE.
- ISSUE:
  - mem_valid=1; mem_addr/wdata/we = payload of grant_sel via muxes.
  - When mem_ready=1, req[grant_sel]_ready=1 combinationally in the same cycle; next state is WAIT.
  - Otherwise hold in ISSUE.
- WAIT:
  - mem_valid=0.
  - When mem_rvalid=1, req[grant_sel]_rvalid=1 in the same cycle; last_grant<=grant_sel; next state is IDLE.

Data and response rules:
- req0_rdata = req1_rdata = mem_rdata at all times; only rvalid is steered.
- mem_rvalid outside WAIT is ignored and never forwarded.

Timing:
- Latency is 1 cycle from req_valid in IDLE to mem_valid.
- Minimum 3 cycles per transaction (IDLE, ISSUE, WAIT); one IDLE cycle always separates transactions.
- grant_sel is stable from ISSUE entry through WAIT exit. The losing requester waits, is never dropped, and wins the next arbitration.

Requester and memory obligations:
- Requester holds valid and payload stable until its ready is seen. Deasserting earlier is a protocol violation; the arbiter does not abandon ISSUE.
- Memory asserts mem_rvalid no earlier than the cycle after mem_ready.

Reset mid-operation: reset in ISSUE or WAIT returns to IDLE next cycle with all outputs at reset values. The aborted transaction's late mem_rvalid is ignored.

Simultaneous events:
- Ready and rvalid to requesters are never both high for different ports in one cycle.
- A new req_valid arriving in WAIT is not sampled until IDLE.

Decomposition:
- Package arb_pkg:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT}
  - localparam REQ_COUNT = 2
- Sub-module: existing Multiplexer2, with in1 = port 0, in2 = port 1 and sel = grant_sel.
  - Multiplexer2 #(ADDR_WIDTH) for address.
  - Multiplexer2 #(DATA_WIDTH) for wdata.
  - Multiplexer2 #(1) for we.
- FSM, last_grant and handshake steering live in mem_port_arbiter itself.

Test Plan:
- Single requester 0, read addr 0x100: mem_ready=1 on first ISSUE cycle, mem_rvalid with rdata 0xDEADBEEF two cycles later -> mem_addr=0x100 the cycle after req0_valid; req0_ready pulses once; req0_rvalid=1 with rdata 0xDEADBEEF; req1_* stay 0; grant_sel=0.
- Both valid from reset, req0 addr 0x10, req1 addr 0x20 -> first mem_addr=0x10; after its rvalid, second mem_addr=0x20 with grant_sel=1; third arbitration with both still valid grants 0.
- Requester 1 write, addr 0x40, wdata 0x55, mem_ready held low 3 cycles -> mem_valid, mem_addr=0x40, mem_we=1 held constant 4 cycles; req1_ready only in the cycle mem_ready=1; busy=1 throughout.
- Stray mem_rvalid pulsed while in IDLE and while in ISSUE -> req0_rvalid=req1_rvalid=0; state unaffected.
- Reset asserted during WAIT, then mem_rvalid the next cycle -> outputs return to reset values; rvalid not forwarded; grant_sel=0; next tie grants requester 0.
